// File: rtl/mux8_32_lane_arbiter_if.sv
// Byte-lane bundle between four requesters and the lane arbiter.
// master: requester side (req/data_in/valid_in); slave: arbiter side.
interface mux8_32_lane_arbiter_if;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic [3:0]  grant;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  owner;
  logic        err_abort;
  logic        err_timeout;

  modport master (
    output req, data_in, valid_in,
    input  grant, data_out, valid_out,
    input  owner, err_abort, err_timeout
  );

  modport slave (
    input  req, data_in, valid_in,
    output grant, data_out, valid_out,
    output owner, err_abort, err_timeout
  );
endinterface

// File: rtl/mux8_32_lane_arbiter.sv
// Round-robin 4-byte burst arbiter for the byte lane of the 8-to-32 packer.
// Ports: clk_4f, reset_L (async low), lane (slave: req/data_in/valid_in in;
// grant/data_out/valid_out/owner/err_abort/err_timeout out).
module mux8_32_lane_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                   clk_4f,
  input  logic                   reset_L,
  mux8_32_lane_arbiter_if.slave  lane
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0] state;
  logic [1:0] beat;
  logic [1:0] last;
  logic [1:0] sel;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       sel_vld;
  logic [7:0] sel_byte;

  // First requesting index after the previous owner, wrapping mod 4.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && lane.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign sel_vld  = lane.valid_in[sel];
  assign sel_byte = lane.data_in[8*sel +: 8];
  assign wait_nxt = wait_cnt + 8'd1;

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state            <= IDLE;
      beat             <= 2'd0;
      wait_cnt         <= 8'd0;
      last             <= 2'd3;
      sel              <= 2'd0;
      lane.grant       <= 4'd0;
      lane.data_out    <= 8'd0;
      lane.valid_out   <= 1'b0;
      lane.owner       <= 2'd0;
      lane.err_abort   <= 1'b0;
      lane.err_timeout <= 1'b0;
    end else begin
      lane.err_abort   <= 1'b0;
      lane.err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          lane.valid_out <= 1'b0;
          if (found) begin
            lane.grant <= 4'b0001 << pick;
            sel        <= pick;
            beat       <= 2'd0;
            wait_cnt   <= 8'd0;
            state      <= XFER;
          end
        end
        XFER: begin
          if (sel_vld) begin
            lane.data_out  <= sel_byte;
            lane.valid_out <= 1'b1;
            lane.owner     <= sel;
            if (beat == 2'd3) begin
              lane.grant <= 4'd0;
              last       <= sel;
              state      <= IDLE;
            end else begin
              beat <= beat + 2'd1;
            end
          end else begin
            lane.valid_out <= 1'b0;
            if (beat == 2'd0) begin
              wait_cnt <= wait_nxt;
              if (wait_nxt == 8'(TIMEOUT)) begin
                lane.err_timeout <= 1'b1;
                lane.grant       <= 4'd0;
                last             <= sel;
                state            <= IDLE;
              end
            end else begin
              // Partial word is dropped downstream once valid_out falls.
              lane.err_abort <= 1'b1;
              lane.grant     <= 4'd0;
              last           <= sel;
              state          <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_32_lane_arbiter.sv
// Directed bench for mux8_32_lane_arbiter with byte scoreboard
// and a behavioural packer model checking assembled words.
module tb_mux8_32_lane_arbiter;

  logic clk_4f;
  logic reset_L;
  int   errors;
  int   checks;
  int   cyc;
  int   n_abort;
  int   n_timeout;
  logic [9:0]  exp_q[$];
  logic [31:0] got_w[$];
  logic [31:0] pk_word;
  int          pk_cnt;

  mux8_32_lane_arbiter_if lane();

  mux8_32_lane_arbiter #(.TIMEOUT(8)) dut (
    .clk_4f (clk_4f),
    .reset_L(reset_L),
    .lane   (lane)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  always @(posedge clk_4f) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_4f) begin
    if (lane.valid_out === 1'b1) begin
      if (exp_q.size() == 0)
        chk("sb_extra_byte", exp_q.size(), 1);
      else
        chk("sb_byte", {lane.owner, lane.data_out}, exp_q.pop_front());
      pk_word = {pk_word[23:0], lane.data_out};
      pk_cnt++;
      if (pk_cnt == 4) begin
        got_w.push_back(pk_word);
        pk_cnt = 0;
      end
    end else begin
      pk_cnt = 0;
    end
    if (lane.err_abort === 1'b1)   n_abort++;
    if (lane.err_timeout === 1'b1) n_timeout++;
    if (reset_L === 1'b1)
      chk("err_excl", lane.err_abort & lane.err_timeout, 0);
  end

  task automatic wait_grant(input int i, input string tag);
    int k;
    k = 0;
    while (lane.grant !== (4'b0001 << i) && k < 40) begin
      @(negedge clk_4f);
      k++;
    end
    chk(tag, lane.grant, 32'(4'b0001 << i));
  endtask

  task automatic send(input int i, input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = w[31-8*k -: 8];
      lane.valid_in[i] = 1'b1;
      lane.data_in[8*i +: 8] = b;
      exp_q.push_back({i[1:0], b});
      @(negedge clk_4f);
    end
    lane.valid_in[i] = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] w);
    if (got_w.size() == 0)
      chk(tag, got_w.size(), 1);
    else
      chk(tag, got_w.pop_front(), w);
  endtask

  initial begin
    int t_prev;
    int na0;
    int nt0;
    int k;
    int seq[5];
    errors = 0; checks = 0; cyc = 0;
    n_abort = 0; n_timeout = 0;
    pk_word = 0; pk_cnt = 0;
    seq = '{0, 1, 2, 3, 0};
    lane.req = 4'd0;
    lane.data_in = 32'd0;
    lane.valid_in = 4'd0;
    reset_L = 1'b0;
    repeat (2) @(negedge clk_4f);
    chk("rst_grant", lane.grant, 0);
    chk("rst_vout", lane.valid_out, 0);
    chk("rst_data", lane.data_out, 0);
    chk("rst_owner", lane.owner, 0);
    chk("rst_errs", {lane.err_abort, lane.err_timeout}, 0);
    reset_L = 1'b1;

    // single requester
    lane.req = 4'b0001;
    wait_grant(0, "t1_grant");
    send(0, 32'h11223344, 4);
    chk("t1_grant_drop", lane.grant, 0);
    lane.req = 4'b0000;
    @(negedge clk_4f);
    check_word("t1_word", 32'h11223344);

    // simultaneous requests from reset
    reset_L = 1'b0;
    @(negedge clk_4f);
    reset_L = 1'b1;
    lane.req = 4'b1010;
    wait_grant(1, "t2_grant1");
    lane.req = 4'b1000;
    send(1, 32'hA1A2A3A4, 4);
    chk("t2_drop1", lane.grant, 0);
    @(negedge clk_4f);
    chk("t2_grant3", lane.grant, 4'b1000);
    send(3, 32'hB1B2B3B4, 4);
    lane.req = 4'b0000;
    @(negedge clk_4f);
    check_word("t2_word1", 32'hA1A2A3A4);
    check_word("t2_word3", 32'hB1B2B3B4);

    // fairness: order 0,1,2,3,0 with period 5
    na0 = n_abort;
    nt0 = n_timeout;
    lane.req = 4'b1111;
    t_prev = 0;
    for (int j = 0; j < 5; j++) begin
      wait_grant(seq[j], "t3_grant");
      if (j > 0) chk("t3_period", cyc - t_prev, 5);
      t_prev = cyc;
      send(seq[j], 32'h10203040 + 32'(j) * 32'h01010101, 4);
      if (j == 4) lane.req = 4'b0000;
    end
    @(negedge clk_4f);
    for (int j = 0; j < 5; j++)
      check_word("t3_word", 32'h10203040 + 32'(j) * 32'h01010101);
    chk("t3_no_abort", n_abort - na0, 0);
    chk("t3_no_timeout", n_timeout - nt0, 0);

    // abort by requester 2, then requester 3
    lane.req = 4'b1100;
    wait_grant(2, "t4_grant2");
    lane.req = 4'b1000;
    send(2, 32'h21222324, 2);
    @(negedge clk_4f);
    chk("t4_abort", lane.err_abort, 1);
    chk("t4_vout", lane.valid_out, 0);
    chk("t4_grant0", lane.grant, 0);
    @(negedge clk_4f);
    chk("t4_abort_pulse", lane.err_abort, 0);
    chk("t4_grant3", lane.grant, 4'b1000);
    chk("t4_no_word", got_w.size(), 0);
    send(3, 32'h31323334, 4);
    lane.req = 4'b0000;
    @(negedge clk_4f);
    check_word("t4_word3", 32'h31323334);

    // timeout on requester 0, then requester 1
    lane.req = 4'b0011;
    wait_grant(0, "t5_grant0");
    k = 0;
    while (lane.err_timeout !== 1'b1 && k < 20) begin
      @(negedge clk_4f);
      k++;
    end
    chk("t5_wait_cycles", k, 8);
    chk("t5_grant_clr", lane.grant, 0);
    chk("t5_no_abort", lane.err_abort, 0);
    @(negedge clk_4f);
    chk("t5_pulse", lane.err_timeout, 0);
    chk("t5_grant1", lane.grant, 4'b0010);
    lane.req = 4'b0000;
    send(1, 32'h41424344, 4);
    @(negedge clk_4f);
    check_word("t5_word1", 32'h41424344);

    // reset mid-burst
    lane.req = 4'b0001;
    wait_grant(0, "t6_grant0");
    send(0, 32'h5A5B5C5D, 2);
    #2 reset_L = 1'b0;
    #1;
    chk("t6_grant", lane.grant, 0);
    chk("t6_vout", lane.valid_out, 0);
    chk("t6_data", lane.data_out, 0);
    chk("t6_owner", lane.owner, 0);
    @(negedge clk_4f);
    reset_L = 1'b1;
    wait_grant(0, "t6_regrant");
    send(0, 32'h61626364, 4);
    lane.req = 4'b0000;
    @(negedge clk_4f);
    check_word("t6_word", 32'h61626364);

    @(negedge clk_4f);
    chk("sb_drained", exp_q.size(), 0);
    chk("words_drained", got_w.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux8_32_lane_arbiter.md
# mux8_32_lane_arbiter

Round-robin arbiter that shares the single 8-bit byte lane feeding the 8-to-32 packer (`Mux8_32`) between four byte-stream requesters. It grants the lane in fixed 4-byte bursts so every 32-bit word assembled downstream comes from exactly one requester and is byte-aligned. It forwards the granted stream as a registered `data_out`/`valid_out` pair clocked by `clk_4f`, tags each byte with its owner, and flags malformed bursts.

## Interface
- `TIMEOUT`, default 8: cycles a granted requester may wait before its first byte (range 1..255).
- `clk_4f`  in  1  lane clock, rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester lane request; bit i is requester i.
- `data_in`  in  32  requester bytes; requester i drives `data_in[8i+7:8i]`.
- `valid_in`  in  4  per-requester byte valid.
- `grant`  out  4  one-hot lane grant, registered.
- `data_out`  out  8  forwarded byte to the packer.
- `valid_out`  out  1  forwarded byte valid.
- `owner`  out  2  index of the requester whose byte is on `data_out`.
- `err_abort`  out  1  one-cycle pulse: valid dropped mid-burst.
- `err_timeout`  out  1  one-cycle pulse: granted requester sent no first byte.

## Operation
- Reset (async, `reset_L`=0): `grant`=0, `data_out`=0, `valid_out`=0, `owner`=0, both error flags 0, state IDLE, beat counter 0, wait counter 0, `last`=3, so requester 0 has first priority.
- States: IDLE, XFER.
- IDLE: `valid_out`<=0. If any `req` bit is set, select the first set bit searching from `last+1` upward, mod 4. Set `grant` to that one-hot value, latch `sel`, clear beat and wait counters, and go to XFER. If no request is set, stay in IDLE.
- XFER, beat 0: if `valid_in[sel]`=1, register `data_out`<=byte of `sel`, `valid_out`<=1, `owner`<=`sel`, and set beat to 1. Otherwise `valid_out`<=0 and increment wait. When wait reaches `TIMEOUT`: pulse `err_timeout`, `grant`<=0, `last`<=`sel`, go to IDLE.
- XFER, beats 1..3: `valid_in[sel]` must be 1 on every cycle. If it is, forward the byte as above and increment beat. When beat 3 is accepted: `grant`<=0, `last`<=`sel`, go to IDLE.
- If `valid_in[sel]`=0 at beat 1..3: pulse `err_abort`, `valid_out`<=0, `grant`<=0, `last`<=`sel`, go to IDLE. Partial bytes already forwarded are not retracted. The packer discards them because its counter clears on `valid_out`=0.
- `req` and `valid_in` of non-granted requesters are ignored. A granted requester that drops `req` mid-burst keeps the grant until the burst completes, aborts or times out.
- `last` updates only when a grant ends. Every ended grant, whether completed, aborted or timed out, passes priority to the next index. This makes the arbiter starvation-free.

## Timing
- Request to grant: `req` sampled high on edge e in IDLE → `grant` high after e.
- Byte latency: `valid_in[sel]` and the byte sampled on edge e → `data_out`/`valid_out`/`owner` valid after e, one-cycle registered latency.
- A burst of 4 bytes on consecutive edges gives 4 consecutive `valid_out` cycles. The packer counts 1..4 and emits the word on the 4th.
- Inter-burst gap: at least one `valid_out`=0 cycle, the IDLE cycle, between any two bursts. This guarantees packer alignment.
- Minimum grant period is 5 cycles: 1 IDLE plus 4 beats. Sustained peak lane utilisation is 4/5.
- Error pulses are high for exactly one cycle, asserted after the edge that detects the condition, and are never both high.
- `grant` falls after the edge accepting beat 3. The requester must not present a 5th byte; any such byte is ignored.
- `reset_L` asserted mid-burst: all outputs clear immediately. Arbitration restarts from requester 0 after release.

## Test plan
- Single requester: `req`=0001, `data_in[7:0]`=11,22,33,44 on consecutive grant cycles → `valid_out` high 4 cycles with 11,22,33,44, `owner`=0, `grant` drops after the 4th, and the packer outputs 0x11223344.
- Simultaneous requests `req`=1010 from reset → requester 1 served first with `owner`=1, then requester 3 after one idle cycle. Words are 0xA1A2A3A4 and 0xB1B2B3B4.
- Fairness: all four `req` held high, each sending 4 bytes on grant → grants in order 0,1,2,3,0 with period 5 cycles, and no `err_*` pulses.
- Abort: requester 2 sends 2 bytes and then deasserts `valid_in[2]` → `err_abort` pulses once, `valid_out`=0, the packer emits no word, and the next grant goes to requester 3 if it is requesting.
- Timeout with `TIMEOUT`=8: requester 0 is granted and never asserts valid → `err_timeout` pulses on the 8th wait cycle, `grant` clears, and requester 1 is granted next.
- Reset mid-burst: `reset_L` pulled low after beat 2 → `grant`, `valid_out`, `data_out` and `owner` read 0 immediately. After release with `req`=0001, a fresh 4-byte burst is forwarded correctly.
